// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment display path.
// Digit format: [5] enable, [4] decimal point, [3:0] digit code.
package seven_segment_pkg;

    typedef logic [5:0] digit_t;

    localparam int unsigned DIGIT_ENABLE_BIT = 5;
    localparam int unsigned DIGIT_DP_BIT     = 4;
    localparam int unsigned DIGIT_CODE_MSB   = 3;

    localparam logic [3:0] DIGIT_CODE_OVERFLOW = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    // 10^n as a 64-bit constant; n is at most 8 here, so no overflow.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_formatter_if.sv
// Value/digit bus between a value source and bcd_digit_formatter.
// master: the source and display consumer; slave: the formatter.
interface bcd_digit_formatter_if #(
    parameter int unsigned NUMBER_OF_DIGITS = 4,
    parameter int unsigned INPUT_WIDTH      = 14
);
    import seven_segment_pkg::*;

    logic [INPUT_WIDTH-1:0]      value;
    logic [NUMBER_OF_DIGITS-1:0] dp_mask;
    logic                        value_valid;
    logic                        value_ready;
    digit_t                      digits [0:NUMBER_OF_DIGITS-1];
    logic                        overflow;
    logic                        done;

    modport master (
        output value, dp_mask, value_valid,
        input  value_ready, digits, overflow, done
    );

    modport slave (
        input  value, dp_mask, value_valid,
        output value_ready, digits, overflow, done
    );

endinterface

// File: rtl/bcd_nibble_adjust.sv
// Double-dabble correction step for one BCD nibble: add 3 when the nibble is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_nibble_adjust (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // Pure combinational add-3 correction.
    always_comb begin
        nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;
    end

endmodule

// File: rtl/bcd_digit_formatter.sv
// Sequential binary-to-BCD front end for the seven-segment display.
// Accepts a value over valid/ready, converts it with a shift-add-3 engine, and holds the last
// completed result on the digit outputs until the next conversion commits.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_digit_formatter
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS = 4,
    parameter int unsigned INPUT_WIDTH      = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    bcd_digit_formatter_if.slave  bus
);

    localparam int unsigned BcdWidth = 4 * NUMBER_OF_DIGITS;
    localparam int unsigned CatWidth = BcdWidth + INPUT_WIDTH;
    localparam int unsigned CntWidth = $clog2(INPUT_WIDTH + 1);
    // Wide enough for both the input value and 10^NUMBER_OF_DIGITS, so the comparison
    // is simply never true when the input range cannot reach the limit.
    localparam int unsigned CmpWidth = (INPUT_WIDTH > 64) ? INPUT_WIDTH : 64;
    localparam logic [63:0] Limit    = pow10(NUMBER_OF_DIGITS);

    state_e                      state_q, state_d;
    logic [INPUT_WIDTH-1:0]      bin_q, bin_d;
    logic [BcdWidth-1:0]         bcd_q, bcd_d;
    logic [CntWidth-1:0]         cnt_q, cnt_d;
    logic [NUMBER_OF_DIGITS-1:0] dp_q, dp_d;
    logic                        ovf_pend_q, ovf_pend_d;
    logic                        overflow_q, overflow_d;
    logic                        done_q, done_d;
    digit_t                      digits_q [0:NUMBER_OF_DIGITS-1];
    digit_t                      digits_d [0:NUMBER_OF_DIGITS-1];
    digit_t                      fmt_digits [0:NUMBER_OF_DIGITS-1];

    logic [BcdWidth-1:0]         bcd_adj;
    logic [CatWidth-1:0]         shifted;
    logic                        ready;

    // One add-3 corrector per decimal digit in the shift datapath.
    for (genvar g = 0; g < NUMBER_OF_DIGITS; g++) begin : gen_adjust
        bcd_nibble_adjust u_adjust (
            .nibble_i (bcd_q[4*g +: 4]),
            .nibble_o (bcd_adj[4*g +: 4])
        );
    end

    // Corrected BCD and remaining binary bits shift left together as one register.
    always_comb begin
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Build the display word for each digit from the finished BCD value.
    always_comb begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic lit;
        lit = 1'b0;
`endif
        for (int k = NUMBER_OF_DIGITS - 1; k >= 0; k--) begin
            logic en;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            // Once a nonzero nibble or a DP is seen from the top, everything below stays lit.
            lit = lit | (bcd_q[4*k +: 4] != 4'd0) | dp_q[k];
            en  = lit | (k == 0);
`else
            en  = 1'b1;
`endif
            fmt_digits[k] = '0;
            fmt_digits[k][DIGIT_DP_BIT] = dp_q[k];
            if (ovf_pend_q) begin
                fmt_digits[k][DIGIT_ENABLE_BIT]   = 1'b1;
                fmt_digits[k][DIGIT_CODE_MSB:0]   = DIGIT_CODE_OVERFLOW;
            end else begin
                fmt_digits[k][DIGIT_ENABLE_BIT]   = en;
                fmt_digits[k][DIGIT_CODE_MSB:0]   = bcd_q[4*k +: 4];
            end
        end
    end

    // FSM next-state and datapath next-state.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_d       = dp_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        digits_d   = digits_q;
        ready      = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.value_valid) begin
                    bin_d      = bus.value;
                    dp_d       = bus.dp_mask;
                    bcd_d      = '0;
                    ovf_pend_d = (CmpWidth'(bus.value) >= CmpWidth'(Limit));
                    cnt_d      = CntWidth'(INPUT_WIDTH);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[CatWidth-1:INPUT_WIDTH];
                bin_d = shifted[INPUT_WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntWidth'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d   = fmt_digits;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dp_q       <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
                digits_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_q       <= dp_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
                digits_q[k] <= digits_d[k];
            end
        end
    end

    assign bus.value_ready = ready;
    assign bus.overflow    = overflow_q;
    assign bus.done        = done_q;
    assign bus.digits      = digits_q;

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Directed bench for bcd_digit_formatter with a result scoreboard.
// Expected displays are pushed at accept time and popped on each done pulse.
module tb_bcd_digit_formatter;
    import seven_segment_pkg::*;

    localparam int unsigned ND = 4;
    localparam int unsigned IW = 14;

    typedef struct packed {
        logic        ovf;
        logic [23:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    exp_t sb [$];

    bcd_digit_formatter_if #(.NUMBER_OF_DIGITS(ND), .INPUT_WIDTH(IW)) bus ();

    bcd_digit_formatter #(.NUMBER_OF_DIGITS(ND), .INPUT_WIDTH(IW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] dut_digits();
        logic [23:0] r;
        for (int k = 0; k < ND; k++) r[6*k +: 6] = bus.digits[k];
        return r;
    endfunction

    // Reference: decimal digits by division, enable from highest nonzero digit / highest DP.
    function automatic exp_t model(input int unsigned v, input logic [3:0] dp);
        exp_t        r;
        int unsigned nib [ND];
        int unsigned t;
        int          msd;
        int          hdp;
        logic        en;
        t   = v;
        msd = 0;
        hdp = 0;
        r.ovf = (v >= 10000);
        for (int k = 0; k < ND; k++) begin
            nib[k] = t % 10;
            t      = t / 10;
        end
        for (int k = 0; k < ND; k++) begin
            if (nib[k] != 0) msd = k;
            if (dp[k])       hdp = k;
        end
        for (int k = 0; k < ND; k++) begin
            en = 1'b1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            en = (k <= msd) || (k <= hdp);
`endif
            if (r.ovf) r.d[6*k +: 6] = {1'b1, dp[k], 4'hE};
            else       r.d[6*k +: 6] = {en, dp[k], 4'(nib[k])};
        end
        return r;
    endfunction

    // Scoreboard consumer: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("digits", {8'h0, dut_digits()}, {8'h0, e.d});
                check("overflow", {31'h0, bus.overflow}, {31'h0, e.ovf});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v, input logic [3:0] dp, input bit push);
        int cyc;
        cyc = 0;
        bus.value       = IW'(v);
        bus.dp_mask     = dp;
        bus.value_valid = 1'b1;
        while (!bus.value_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("accept_timeout", {31'h0, cyc < 100}, 32'd1);
        if (push) sb.push_back(model(v, dp));
        tick();
        bus.value_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        tick();
    endtask

    initial begin
        int   cyc;
        exp_t prev;

        rst             = 1'b1;
        bus.value       = '0;
        bus.dp_mask     = '0;
        bus.value_valid = 1'b0;
        repeat (3) tick();
        check("reset_ready", {31'h0, bus.value_ready}, 32'd1);
        check("reset_done", {31'h0, bus.done}, 32'd0);
        check("reset_overflow", {31'h0, bus.overflow}, 32'd0);
        check("reset_digits", {8'h0, dut_digits()}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {31'h0, bus.value_ready}, 32'd1);

        // 1234: latency and basic conversion.
        send(1234, 4'b0000, 1'b1);
        check("ready_drops", {31'h0, bus.value_ready}, 32'd0);
        check("no_early_done", {31'h0, bus.done}, 32'd0);
        cyc = 0;
        while (!bus.done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("latency", cyc, 32'd15);
        check("ready_on_done", {31'h0, bus.value_ready}, 32'd1);
        wait_done();

        // Zero, then 7 with a DP on digit 2.
        send(0, 4'b0000, 1'b1);
        wait_done();
        send(7, 4'b0100, 1'b1);
        wait_done();
        send(5067, 4'b1001, 1'b1);
        wait_done();

        // Overflow and recovery.
        send(10000, 4'b0010, 1'b1);
        wait_done();
        check("overflow_set", {31'h0, bus.overflow}, 32'd1);
        send(16383, 4'b0000, 1'b1);
        wait_done();
        send(9999, 4'b0000, 1'b1);
        wait_done();
        check("overflow_clear", {31'h0, bus.overflow}, 32'd0);

        // Valid held high with changing value while busy.
        send(321, 4'b0000, 1'b1);
        bus.value_valid = 1'b1;
        cyc = 0;
        while (!bus.value_ready && cyc < 100) begin
            bus.value = IW'((cyc * 517) % 10000 + 1);
            tick();
            cyc++;
        end
        check("busy_cycles", cyc, 32'd15);
        check("accept_on_done", {31'h0, bus.done}, 32'd1);
        bus.value   = IW'(4321);
        bus.dp_mask = 4'b0001;
        sb.push_back(model(4321, 4'b0001));
        tick();
        bus.value_valid = 1'b0;
        check("ready_drops_2", {31'h0, bus.value_ready}, 32'd0);
        prev = model(321, 4'b0000);
        cyc = 0;
        while (!bus.done && cyc < 50) begin
            check("hold_digits", {8'h0, dut_digits()}, {8'h0, prev.d});
            tick();
            cyc++;
        end
        wait_done();

        // Reset 5 cycles into a conversion.
        send(9876, 4'b0010, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_digits", {8'h0, dut_digits()}, 32'd0);
        check("abort_overflow", {31'h0, bus.overflow}, 32'd0);
        rst = 1'b0;
        tick();
        check("abort_ready", {31'h0, bus.value_ready}, 32'd1);
        cyc = done_count;
        repeat (20) tick();
        check("abort_no_done", done_count, cyc);
        check("abort_digits_hold", {8'h0, dut_digits()}, 32'd0);
        send(42, 4'b0000, 1'b1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
